// File: rtl/deskew_collector.sv
// Re-aligns staggered systolic-array lane outputs into whole rows and queues them in a small FIFO.
// Latency: a row started in cycle t is visible on out_valid/out_data in cycle t+LANES (empty FIFO, no bypass).
// Backpressure: out_ready stalls the FIFO head; rows arriving while full (and not popping) are dropped, sticky overflow.
module deskew_collector #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [LANES*WIDTH-1:0]       in_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [LANES*WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic [15:0]                  row_count
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [LANES*WIDTH-1:0] w_push_word;
  logic [LANES-2:0]       r_vld_sr;
  logic                   w_push_v;

  // The last lane arrives latest, so it feeds the aligned word directly.
  assign w_push_word[(LANES-1)*WIDTH +: WIDTH] = in_data[(LANES-1)*WIDTH +: WIDTH];

  // Lane i is delayed by LANES-1-i registers so that every lane of a row lines up with the last lane.
  for (genvar i = 0; i < LANES-1; i++) begin : g_lane
    localparam int D = LANES-1-i;
    logic [WIDTH-1:0] r_sh [D];

    // Per-lane delay line; partial rows are discarded on reset.
    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        for (int d = 0; d < D; d++) r_sh[d] <= '0;
      end else begin
        r_sh[0] <= in_data[i*WIDTH +: WIDTH];
        for (int d = 1; d < D; d++) r_sh[d] <= r_sh[d-1];
      end
    end

    assign w_push_word[i*WIDTH +: WIDTH] = r_sh[D-1];
  end

  // Row-start marker travels alongside the slowest lane; emerging bit means a complete row is present.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_vld_sr <= '0;
    end else begin
      r_vld_sr[0] <= in_valid;
      for (int k = 1; k < LANES-1; k++) r_vld_sr[k] <= r_vld_sr[k-1];
    end
  end

  assign w_push_v = r_vld_sr[LANES-2];

  // Aligned-row FIFO
  logic [LANES*WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [LW-1:0]          r_level;
  logic                   r_overflow;
  logic [15:0]            r_row_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still takes the row.
  assign w_push  = w_push_v && (!w_full || w_pop);
  assign w_drop  = w_push_v && w_full && !w_pop;

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_push_word;
  end

  // Pointers, occupancy, sticky overflow and accepted-row counter.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_row_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr      <= r_wptr + 1'b1;
        r_row_count <= r_row_count + 16'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = out_valid ? r_mem[r_rptr] : '0;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign row_count = r_row_count;

endmodule

// File: tb/tb_deskew_collector.sv
// Bench for deskew_collector (LANES=4, WIDTH=8, DEPTH=4).
// A queue-level model tracks expected FIFO contents and is compared every cycle,
// directed scenarios add literal expectations.
module tb_deskew_collector;

  localparam int L = 4;
  localparam int W = 8;
  localparam int D = 4;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [2:0]    level;
  logic          overflow;
  logic [15:0]   row_count;

  deskew_collector #(.LANES(L), .WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .level(level), .overflow(overflow), .row_count(row_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [31:0] row; } pend_t;
  pend_t       m_pend[$];
  logic [31:0] m_q[$];
  int          m_cnt = 0;
  bit          m_ovf = 0;
  logic [31:0] cur_row = '0;

  function automatic void m_clear();
    m_pend.delete();
    m_q.delete();
    m_cnt = 0;
    m_ovf = 0;
  endfunction

  always @(posedge rst) m_clear();

  always @(posedge clock) begin
    if (rst) begin
      m_clear();
    end else begin
      bit full_before, pop, push;
      logic [31:0] prow;
      full_before = (m_q.size() == D);
      pop  = (m_q.size() != 0) && out_ready;
      push = 0;
      prow = '0;
      if (m_pend.size() != 0 && m_pend[0].due == cyc) begin
        push = 1;
        prow = m_pend[0].row;
        void'(m_pend.pop_front());
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full_before || pop) begin
          m_q.push_back(prow);
          m_cnt = (m_cnt + 1) % 65536;
        end else begin
          m_ovf = 1;
        end
      end
      if (in_valid) m_pend.push_back('{cyc + L - 1, cur_row});
    end
    cyc++;
  end

  // Every-cycle comparison of DUT against the model.
  always @(posedge clock) begin
    #2;
    chk("m_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("m_data", out_data, m_q[0]);
    chk("m_level", {29'b0, level}, m_q.size());
    chk("m_ovf", {31'b0, overflow}, {31'b0, m_ovf});
    chk("m_rowcnt", {16'b0, row_count}, m_cnt);
  end

  // ---------------- stimulus ----------------
  bit          h_v   [1024];
  logic [31:0] h_row [1024];

  task automatic drive(input bit v, input logic [31:0] row, input bit rdy);
    @(negedge clock);
    in_valid  = v;
    out_ready = rdy;
    cur_row   = row;
    h_v[cyc % 1024]   = v;
    h_row[cyc % 1024] = row;
    for (int i = 0; i < L; i++) begin
      int c;
      c = cyc - i;
      if (c >= 0 && h_v[c % 1024]) in_data[i*W +: W] = h_row[c % 1024][i*W +: W];
      else                         in_data[i*W +: W] = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) h_v[i] = 0;
  endtask

  function automatic logic [31:0] mkrow(input logic [7:0] b);
    logic [31:0] r;
    for (int j = 0; j < L; j++) r[j*W +: W] = b + 8'(16 * j);
    return r;
  endfunction

  initial begin
    int nv;
    logic [31:0] last;
    for (int i = 0; i < 1024; i++) h_v[i] = 0;
    #1;
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_level", {29'b0, level}, 32'd0);
    chk("reset_rowcnt", {16'b0, row_count}, 32'd0);
    do_reset();

    // 1: single row
    for (int k = 0; k < 8; k++) begin
      drive(k == 0, 32'h44332211, 1'b1);
      chk("t1_valid", {31'b0, out_valid}, {31'b0, k == 4});
      if (k == 4) chk("t1_data", out_data, 32'h44332211);
    end
    chk("t1_rowcnt", {16'b0, row_count}, 32'd1);

    // 2: streaming 8 rows back to back
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(k < 8, mkrow(8'(k)), 1'b1);
      chk("t2_valid", {31'b0, out_valid}, {31'b0, (k >= 4 && k < 12)});
      if (k >= 4 && k < 12) chk("t2_data", out_data, mkrow(8'(k - 4)));
      chk("t2_level_le1", {31'b0, level <= 3'd1}, 32'd1);
    end
    chk("t2_rowcnt", {16'b0, row_count}, 32'd8);
    chk("t2_ovf", {31'b0, overflow}, 32'd0);

    // 3 + 5: backpressure, overflow, hold stability, drain
    do_reset();
    for (int k = 0; k < 18; k++) begin
      drive(k < 5, mkrow(8'(8'h80 + k)), 1'b0);
      if (k >= 8) begin
        chk("t3_level", {29'b0, level}, 32'd4);
        chk("t5_hold", out_data, mkrow(8'h80));
      end
    end
    chk("t3_ovf", {31'b0, overflow}, 32'd1);
    chk("t3_rowcnt", {16'b0, row_count}, 32'd4);
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, '0, 1'b1);
      if (out_valid) begin
        chk("t3_drain", out_data, mkrow(8'(8'h80 + nv)));
        nv++;
      end
    end
    chk("t3_ndrain", nv, 32'd4);
    chk("t3_ovf_held", {31'b0, overflow}, 32'd1);

    // 4: full FIFO with simultaneous push and pop
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(k < 5, mkrow(8'(8'hA0 + k)), k == 7);
      if (k == 7) chk("t4_full", {29'b0, level}, 32'd4);
    end
    chk("t4_level", {29'b0, level}, 32'd4);
    chk("t4_ovf", {31'b0, overflow}, 32'd0);
    chk("t4_rowcnt", {16'b0, row_count}, 32'd5);
    chk("t4_head", out_data, mkrow(8'hA1));
    nv = 0;
    last = '0;
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, '0, 1'b1);
      if (out_valid) begin
        nv++;
        last = out_data;
      end
    end
    chk("t4_ndrain", nv, 32'd4);
    chk("t4_last", last, mkrow(8'hA4));

    // 6: asynchronous reset with a row stored and another in flight
    for (int k = 0; k < 8; k++) drive(k == 0 || k == 5, mkrow(8'(8'hC0 + k)), 1'b0);
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_data", out_data, 32'd0);
    chk("t6_rst_level", {29'b0, level}, 32'd0);
    chk("t6_rst_rowcnt", {16'b0, row_count}, 32'd0);
    @(negedge clock);
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, '0, 1'b1);
      chk("t6_no_valid", {31'b0, out_valid}, 32'd0);
    end
    chk("t6_level", {29'b0, level}, 32'd0);
    chk("t6_rowcnt", {16'b0, row_count}, 32'd0);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/deskew_collector.md
Name: deskew_collector

Overview:
- Output-side counterpart of the input skew delay registers feeding the systolic MAC array.
- The array emits row results staggered: lane i arrives i cycles after lane 0.
- This block re-aligns all lanes into one word per row, buffers the rows in a small FIFO, and presents them on a valid/ready handshake to the downstream softmax/writeback stage.

Parameters:
- LANES, 4, number of array output lanes (≥2).
- WIDTH, 8, bits per lane.
- DEPTH, 4, aligned-row FIFO depth (power of two, ≥2).

Ports:
- clock  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies lane 0 of a new row this cycle.
- in_data  input  LANES*WIDTH  skewed lane data; lane i at bits [i*WIDTH +: WIDTH].
- out_ready  input  1  downstream accepts the head row.
- out_valid  output  1  FIFO non-empty.
- out_data  output  LANES*WIDTH  aligned head row; lane i at same bit position as input.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky: a row was dropped because the FIFO was full.
- row_count  output  16  number of rows accepted into the FIFO, wraps modulo 2^16.

Behaviour:
- Clock and reset: one clock, `clock`; reset is asynchronous and active-high (`rst`).
- Reset values (asserted asynchronously):
  - all skew registers and the valid pipeline = 0;
  - FIFO empty, out_valid=0, out_data=0, level=0, overflow=0, row_count=0.
- Input timing: a row started with in_valid high in cycle t has lane i valid on in_data in cycle t+i. There is no per-lane valid.
- Deskew:
  - lane i passes through LANES-1-i pipeline registers; lane LANES-1 passes with zero registers;
  - in_valid passes through LANES-1 registers → push_v;
  - in cycle t+LANES-1 all lanes of the row are simultaneously present → push_word.
- Push: on the rising edge ending cycle t+LANES-1, if push_v=1:
  - if FIFO not full, or a pop occurs on the same edge: write push_word, row_count+1;
  - otherwise drop the word, set overflow=1 (held until rst), row_count unchanged.
- Latency: the row is first visible (out_valid=1, out_data=row) in cycle t+LANES when the FIFO was empty. There is no bypass path.
- Pop: occurs on an edge where out_valid && out_ready; the head advances. out_ready while empty has no effect.
- Simultaneous push and pop:
  - when the FIFO is non-empty, level is unchanged;
  - when full, the push is accepted (the pop frees the slot), no overflow;
  - when empty, no pop occurs; only the push takes effect.
- Back-to-back rows: in_valid may be high every cycle. Full throughput is one row per cycle with out_ready held high.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `level`.
- Stability: out_data is stable while out_valid && !out_ready.
- Reset mid-operation: in-flight partial rows in the skew pipeline are discarded. No row is emitted after rst deasserts until a new in_valid arrives.
- in_data lanes outside an active row are don't-care; they never reach the FIFO unless push_v is set.
- There is no combinational path from any input to out_valid or out_data. level and overflow are registered.

Test Plan (LANES=4, WIDTH=8, DEPTH=4):
1. Single row:
   - stimulus: in_valid at cycle 0 with lane0=0x11, lane1=0x22 at cycle 1, lane2=0x33 at cycle 2, lane3=0x44 at cycle 3; out_ready=1;
   - required: out_valid=1 only in cycle 4 with out_data=0x44332211; row_count=1.
2. Streaming:
   - stimulus: 8 consecutive rows with row k lanes = {k,k,k,k}+0x10*lane, each lane correctly skewed; out_ready=1;
   - required: 8 consecutive out_valid cycles starting at cycle 4, in order; level ≤1; overflow=0; row_count=8.
3. Backpressure and overflow:
   - stimulus: out_ready=0, push 5 rows;
   - required: level reaches 4; the 5th row is dropped; overflow=1; row_count=4.
   - then raise out_ready: rows 0–3 drain in order, the 5th never appears, overflow remains 1.
4. Full with simultaneous pop:
   - stimulus: fill the FIFO to 4, then assert out_ready on the same edge as the next push;
   - required: level stays 4, no overflow, new row appears after the 4 older rows.
5. Hold stability:
   - stimulus: out_valid=1, out_ready=0 for 10 cycles;
   - required: out_data unchanged every cycle.
6. Reset mid-row:
   - stimulus: in_valid at cycle 0, assert rst asynchronously at cycle 2 mid-cycle, deassert at cycle 3;
   - required: outputs go to 0 immediately on rst; no out_valid afterward; level=0, row_count=0.
